// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result handshake bundle for seq_mult_unit.
// Ports: in_valid/in_ready + multiplicand/multiplier/signed_mode (request),
//        out_valid/out_ready + product (response), busy (status).
interface seq_mult_if #(
  parameter int WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   signed_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  // Requester / consumer side.
  modport master (
    output in_valid, multiplicand, multiplier, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  // Multiplier unit side.
  modport slave (
    input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_unit.sv
// seq_mult_unit: shift-and-add multiplier, one multiplier bit per cycle.
// Latency: out_valid rises WIDTH+1 edges after the accept edge (load + WIDTH iterations).
// Backpressure: product held in DONE until out_ready; in_ready low while CALC/DONE.
// Ports: clk, reset (sync, active-high), bus (seq_mult_if.slave).
// Optional: define SEQ_MULT_SIGNED_EN to honour signed_mode (two's complement
// operands via magnitude multiply + conditional negate); otherwise signed_mode
// is ignored and every operation is unsigned.
module seq_mult_unit #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  seq_mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplier_q,  mplier_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic               neg_q,     neg_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;

`ifdef SEQ_MULT_SIGNED_EN
  assign a_neg = bus.signed_mode & bus.multiplicand[WIDTH-1];
  assign b_neg = bus.signed_mode & bus.multiplier[WIDTH-1];
`else
  logic unused_signed_mode;
  assign unused_signed_mode = bus.signed_mode;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  // Negating -2^(WIDTH-1) wraps back to 2^(WIDTH-1), which read as unsigned
  // is exactly the required magnitude.
  assign a_mag = a_neg ? ({WIDTH{1'b0}} - bus.multiplicand) : bus.multiplicand;
  assign b_mag = b_neg ? ({WIDTH{1'b0}} - bus.multiplier)   : bus.multiplier;

  // Add into the upper half keeping the carry, then shift {carry, acc} right.
  // The bit shifted out of the bottom is dropped.
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign acc_next = {sum, acc_q[WIDTH-1:1]};

  logic unused_acc_lsb;
  assign unused_acc_lsb = acc_q[0];

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last iteration: result is final, publish it as DONE is entered.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = S_DONE;
          product_d = neg_q ? ({(2*WIDTH){1'b0}} - acc_next) : acc_next;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit: directed self-checking bench for seq_mult_unit (WIDTH=16).
// Ports: none; drives seq_mult_if master side, clk and reset.
// Signed expectations follow SEQ_MULT_SIGNED_EN when it is defined for the build.
module tb_seq_mult_unit;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation from IDLE: accept, optional junk pulse in CALC,
  // latency check, optional backpressure hold with in_valid asserted, consume.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] exp,
                        input int hold, input bit pulse);
    int edges;
    check({tag, ":idle_rdy"}, bus.in_ready, 1'b1);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.signed_mode  = s;
    bus.in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, ":calc_busy"}, bus.busy, 1'b1);
    check({tag, ":calc_rdy"}, bus.in_ready, 1'b0);
    edges = 1;
    while (!bus.out_valid && edges < 60) begin
      if (pulse && edges == 4) begin
        bus.multiplicand = 16'hAAAA;
        bus.multiplier   = 16'h5555;
        bus.in_valid     = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({tag, ":latency"}, 64'(edges), 64'(W + 1));
    check({tag, ":product"}, bus.product, exp);
    check({tag, ":done_rdy"}, bus.in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      bus.multiplicand = 16'h0F0F;
      bus.multiplier   = 16'h0F0F;
      bus.in_valid     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, ":hold_vld"}, bus.out_valid, 1'b1);
      check({tag, ":hold_prod"}, bus.product, exp);
      check({tag, ":hold_rdy"}, bus.in_ready, 1'b0);
    end
    // in_valid may still be high here: it coincides with the output handshake.
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, ":post_vld"}, bus.out_valid, 1'b0);
    check({tag, ":post_rdy"}, bus.in_ready, 1'b1);
    check({tag, ":post_busy"}, bus.busy, 1'b0);
    check({tag, ":post_prod"}, bus.product, exp);
  endtask

  initial begin
    int seen;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.signed_mode  = 1'b0;
    reset            = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_product", bus.product, 64'h0);
    reset = 1'b0;

    // First edge after reset release accepts.
    run_op("umax", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, 1'b0);
    run_op("zero", 16'h0000, 16'h1234, 1'b0, 32'h00000000, 0, 1'b0);
    run_op("ident", 16'h0001, 16'hABCD, 1'b0, 32'h0000ABCD, 0, 1'b0);
    run_op("bp", 16'h1234, 16'h5678, 1'b0, 32'h06260060, 5, 1'b0);

`ifdef SEQ_MULT_SIGNED_EN
    run_op("s_m3x5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 0, 1'b0);
    run_op("s_minmin", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, 1'b0);
    run_op("s_minx1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 0, 1'b0);
`else
    run_op("s_m3x5", 16'hFFFD, 16'h0005, 1'b1, 32'h0004FFF1, 0, 1'b0);
    run_op("s_minmin", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, 1'b0);
    run_op("s_minx1", 16'h8000, 16'h0001, 1'b1, 32'h00008000, 0, 1'b0);
`endif

    // Junk in_valid pulse during CALC must not disturb the result or start a second op.
    run_op("ign", 16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, 0, 1'b1);
    seen = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid || bus.busy) seen++;
    end
    bus.out_ready = 1'b0;
    check("ign_no_second", 64'(seen), 64'h0);

    // Reset sampled at the edge ending CALC cycle 7 aborts the operation.
    bus.multiplicand = 16'h7777;
    bus.multiplier   = 16'h9999;
    bus.signed_mode  = 1'b0;
    bus.in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_busy", bus.busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_vld", bus.out_valid, 1'b0);
    check("mid_rst_rdy", bus.in_ready, 1'b1);
    check("mid_rst_prod", bus.product, 64'h0);
    check("mid_rst_busy", bus.busy, 1'b0);
    run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 32'h0000000C, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_unit.md
SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, operand width in bits; legal range 2..64.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, synchronous, active-high reset sampled on rising clk.
REQ-004 The module SHALL have port in_valid, input, 1, operands and mode present.
REQ-005 The module SHALL have port in_ready, output, 1, unit idle and able to accept operands.
REQ-006 The module SHALL have port multiplicand, input, WIDTH, operand A.
REQ-007 The module SHALL have port multiplier, input, WIDTH, operand B.
REQ-008 The module SHALL have port signed_mode, input, 1, treat A/B as two's complement.
REQ-009 The module SHALL have port out_valid, output, 1, product available.
REQ-010 The module SHALL have port out_ready, input, 1, consumer accepts the product.
REQ-011 The module SHALL have port product, output, 2*WIDTH, result of A*B.
REQ-012 The module SHALL have port busy, output, 1, high in states CALC and DONE.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE; encoding is free and any unreachable encoding SHALL return to IDLE on the next edge.
REQ-014 In IDLE: in_ready=1; on in_valid=1 at an edge, the unit SHALL latch the operands and signed_mode, clear the accumulator, clear the iteration counter, and go to CALC.
REQ-015 In CALC: each cycle, if the LSB of the shifted multiplier is 1, the unit SHALL add the multiplicand into the accumulator upper half (WIDTH+1-bit carry kept), then shift {carry, acc} right by 1 and increment the counter.
REQ-016 After exactly WIDTH CALC cycles the FSM SHALL go to DONE; the counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap.
REQ-017 Latency: out_valid SHALL rise exactly WIDTH+1 cycles after the accept edge, counted as 1 load edge plus WIDTH iteration edges.
REQ-018 In DONE: out_valid=1 and product SHALL hold stable until out_valid and out_ready are both 1 at an edge, then the FSM SHALL go to IDLE.
REQ-019 in_ready SHALL be 0 in CALC and DONE; in_valid there SHALL be ignored, including an in_valid coincident with the output handshake, which is accepted no earlier than the following IDLE cycle.
REQ-020 out_valid SHALL be 0 outside DONE; product SHALL hold its last value outside DONE and SHALL never change without a new accept.
REQ-021 Unsigned operation SHALL yield the exact 2*WIDTH-bit product, with no truncation.

Reset
REQ-022 When reset=1 at an edge, the FSM SHALL go to IDLE, with in_ready=1, out_valid=0, busy=0, product=0, and the accumulator and counter cleared.
REQ-023 Reset SHALL take priority over every handshake; reset during CALC or DONE SHALL abort the operation with no output handshake.
REQ-024 The first edge after reset deasserts SHALL be able to accept operands.

Configuration
REQ-025 Macro SEQ_MULT_SIGNED_EN defined: with signed_mode=1, the unit SHALL take operand magnitudes at load, multiply unsigned, and two's-complement negate the product on DONE entry when the signs differ; latency SHALL be unchanged.
REQ-026 Macro SEQ_MULT_SIGNED_EN defined: -2^(WIDTH-1) operands SHALL be handled exactly, with magnitude 2^(WIDTH-1).
REQ-027 Macro SEQ_MULT_SIGNED_EN undefined: the signed_mode port SHALL remain, SHALL be ignored, and all operations SHALL be unsigned.

Verification (WIDTH=16)
REQ-028 Unsigned max: A=0xFFFF, B=0xFFFF -> product=0xFFFE0001, with out_valid rising 17 cycles after the accept edge.
REQ-029 Zero and identity: A=0x0000, B=0x1234 -> 0x00000000; then A=0x0001, B=0xABCD -> 0x0000ABCD.
REQ-030 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid=1, product stable, in_ready=0 throughout; accept happens on the first cycle out_ready=1.
REQ-031 Signed, with SEQ_MULT_SIGNED_EN: A=0xFFFD (-3), B=0x0005 -> 0xFFFFFFF1; A=0x8000, B=0x8000 -> 0x40000000; without the macro, the same A=0x8000, B=0x8000 with signed_mode=1 -> 0x40000000 as an unsigned product.
REQ-032 Reset mid-operation: reset asserted on CALC cycle 7 -> next cycle out_valid=0, in_ready=1, product=0; a new op A=3, B=4 -> 0x0000000C with normal latency.
REQ-033 Ignored input: in_valid pulsed with different operands during CALC -> the first result is unaffected and no second result appears.
